wb_drv_config_mc: RTL and testbench
===================================

# wb_drv_config_mc

Multi-channel, parametrised Wishbone configuration block for the LVDS transmitter driver array. It holds per-channel delay-line settings (sync, P, N) and bias-current codes in shadow registers. It transfers them atomically to the active outputs on a frame boundary, or immediately in auto-commit mode. It sits between the Caravel Wishbone bus and NUM_CH analog driver slices.

## Interface
Parameters:
- NUM_CH, 2, number of driver channels (1..60)
- DEL_W, 16, delay-code width (1..32)
- CUR_W, 32, current-code width (1..32)
- BASE_ADDR, 32'h0300_0000, page base; decode on addr[31:8]
- COMMIT_TIMEOUT, 1024, cycles in ARMED before forced apply; 0 = no timeout

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  32  address; register index = addr[7:0]
- i_wb_data  in  32  write data
- o_wb_ack  out  1  acknowledge
- o_wb_stall  out  1  stall (combinational)
- o_wb_data  out  32  read data
- i_frame_sync  in  1  frame-boundary commit strobe
- o_del_sync, o_del_p, o_del_n  out  NUM_CH*DEL_W  active delay codes; channel c at [c*DEL_W +: DEL_W]
- o_del_sync_inv, o_del_p_inv, o_del_n_inv  out  NUM_CH*DEL_W  bitwise inverse of the matching output
- o_current  out  NUM_CH*CUR_W  active current codes
- o_commit_busy  out  1  high while in ARMED

## Operation
- Register map, with index i = addr[7:0]:
  - For i = 4c+k, c < NUM_CH: k=0 DEL_SYNC, 1 DEL_P, 2 DEL_N, 3 CURRENT. Writes go to the shadow register and take the low DEL_W or CUR_W bits.
  - 0xF0 CTRL: bit0 COMMIT (write 1 = request; reads 0), bit1 AUTO.
  - 0xF1 STATUS: bit0 ARMED (RO), bit1 TIMEOUT (sticky; write 1 to clear).
  - 0xF2 ID (RO): {NUM_CH[7:0], DEL_W[7:0], CUR_W[7:0], 8'h02}.
  - Other indices inside the page: ack, read 0, write ignored.
  - addr[31:8] != BASE_ADDR[31:8]: ignored, no ack.
- Accept condition: cyc & stb & !stall and in-page address.
- Commit FSM, IDLE/ARMED:
  - IDLE -> ARMED on an accepted CTRL write with bit0=1.
  - ARMED -> IDLE when i_frame_sync=1: all active registers take the shadow values on that edge.
  - ARMED -> IDLE when the timeout counter reaches COMMIT_TIMEOUT-1: apply, set TIMEOUT.
  - COMMIT request while ARMED: ignored.
- o_wb_stall = ARMED & cyc & stb & we & the address targets a channel register. Reads and CTRL/STATUS/ID accesses never stall.
- AUTO=1: a channel write updates shadow and active on the same edge.
- Reset: state IDLE, counter 0. All shadow, active, CTRL and STATUS bits are 0. o_wb_ack=0, o_wb_data=0, all *_inv outputs all-ones, o_commit_busy=0.

## Timing
- Ack is registered, one cycle after acceptance, one pulse per request. Back-to-back requests give one ack per cycle.
- o_wb_data is valid in the ack cycle and 0 otherwise. Read data is zero-extended.
- Ack is issued even if cyc drops in the ack cycle.
- Active outputs change on the apply edge and are visible the next cycle.
- *_inv outputs are combinational from the active registers.
- A COMMIT write accepted with i_frame_sync=1 in the same cycle does not apply. The FSM enters ARMED and waits for the next sync.
- Timeout counter: cleared on ARMED entry, counts +1 per ARMED cycle. If sync and timeout hit together, apply once and do not set TIMEOUT.
- Reset while ARMED: return to IDLE with no apply, active registers cleared.

## Configuration
- DRV_CFG_READBACK_EN defined: reads return shadow/CTRL/STATUS/ID contents as mapped.
- DRV_CFG_READBACK_EN undefined: every read acks with o_wb_data=0. Writes and the FSM are unchanged, and the read mux is removed.

## Test plan
- Reset, then idle: o_del_sync_inv all-ones, o_current=0, o_wb_ack=0, ID read = {02,10,20,02} with the macro defined.
- Write 0xFFFF_FFFF to 0x0300_0001 (ch0 DEL_P), then CTRL=1, then i_frame_sync pulse after 5 cycles: o_del_p[15:0] stays 0 until the sync edge, then 0xFFFF and o_del_p_inv[15:0]=0.
- In ARMED, write ch1 CURRENT (0x0300_0007): o_wb_stall=1 until sync. After the apply, the write is accepted and lands in shadow only.
- COMMIT_TIMEOUT=8, CTRL=1, no sync: apply after 8 ARMED cycles, STATUS=0x2. Write STATUS=0x2 to clear it, then read 0x0.
- CTRL=0x2 (AUTO), write 0x1234 to ch1 DEL_N: o_del_n[31:16]=0x1234 in the ack cycle, with no sync.
- Read 0x0300_00F5 and 0x0400_0000: the first acks with 0, the second gets no ack within 4 cycles.

Source files
------------

// File: rtl/wb_drv_config_mc.sv
// wb_drv_config_mc: Wishbone configuration block for the LVDS driver array.
// Holds per-channel delay codes (sync, P, N) and current codes in shadow
// registers. A commit FSM (IDLE/ARMED) copies all shadows into the active
// registers on a frame sync, or on a timeout. In AUTO mode, channel writes
// reach the active outputs directly.
// Build option: define DRV_CFG_READBACK_EN to enable register readback.
// Without it, every read acks with data 0.
//
// Bus handshake: the master holds cyc & stb (valid). A request is taken on
// a rising edge when o_wb_stall is low (ready) and the address is in page.
// Each taken request produces exactly one registered ack on the next cycle,
// even if cyc has dropped by then.
module wb_drv_config_mc #(
  parameter int          NUM_CH         = 2,
  parameter int          DEL_W          = 16,
  parameter int          CUR_W          = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
  parameter int          COMMIT_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [31:0]             i_wb_addr,
  input  logic [31:0]             i_wb_data,
  output logic                    o_wb_ack,
  output logic                    o_wb_stall,
  output logic [31:0]             o_wb_data,
  input  logic                    i_frame_sync,
  output logic [NUM_CH*DEL_W-1:0] o_del_sync,
  output logic [NUM_CH*DEL_W-1:0] o_del_p,
  output logic [NUM_CH*DEL_W-1:0] o_del_n,
  output logic [NUM_CH*DEL_W-1:0] o_del_sync_inv,
  output logic [NUM_CH*DEL_W-1:0] o_del_p_inv,
  output logic [NUM_CH*DEL_W-1:0] o_del_n_inv,
  output logic [NUM_CH*CUR_W-1:0] o_current,
  output logic                    o_commit_busy
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_e;

  localparam int          DW     = NUM_CH * DEL_W;
  localparam int          CW     = NUM_CH * CUR_W;
  localparam bit          TO_EN  = (COMMIT_TIMEOUT > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(COMMIT_TIMEOUT - 1) : 32'd0;
  localparam logic [9:0]  CH_LIM = 10'(4 * NUM_CH);

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            auto_q, auto_d;
  logic            timeout_q, timeout_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [DW-1:0]   shd_sync_q, shd_sync_d, shd_p_q, shd_p_d, shd_n_q, shd_n_d;
  logic [DW-1:0]   act_sync_q, act_sync_d, act_p_q, act_p_d, act_n_q, act_n_d;
  logic [CW-1:0]   shd_cur_q, shd_cur_d, act_cur_q, act_cur_d;

  logic [7:0] idx;
  logic       in_page, is_ch, armed;
  logic       acc, wr, rd, ch_wr, ctrl_wr, status_wr;
  logic       timeout_hit, apply;

  // Address decode, stall and accept qualification
  always_comb begin
    idx         = i_wb_addr[7:0];
    in_page     = (i_wb_addr[31:8] == BASE_ADDR[31:8]);
    is_ch       = ({2'b00, idx} < CH_LIM);
    armed       = (state_q == ARMED);
    o_wb_stall  = armed & i_wb_cyc & i_wb_stb & i_wb_we & in_page & is_ch;
    acc         = i_wb_cyc & i_wb_stb & ~o_wb_stall & in_page;
    wr          = acc & i_wb_we;
    rd          = acc & ~i_wb_we;
    ch_wr       = wr & is_ch;
    ctrl_wr     = wr & (idx == 8'hF0);
    status_wr   = wr & (idx == 8'hF1);
    timeout_hit = armed & TO_EN & (cnt_q == TO_LAST);
    apply       = armed & (i_frame_sync | timeout_hit);
  end

  // Commit FSM next state, timeout counter and CTRL/STATUS bits
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    auto_d    = auto_q;
    timeout_d = timeout_q;
    if (ctrl_wr) auto_d = i_wb_data[1];
    if (status_wr && i_wb_data[1]) timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_wr && i_wb_data[0]) begin
          state_d = ARMED;
          cnt_d   = 32'd0;
        end
      end
      ARMED: begin
        cnt_d = cnt_q + 32'd1;
        if (apply) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          // A coincident sync counts as a normal commit, not a timeout.
          if (timeout_hit && !i_frame_sync) timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow and active register updates (write, apply, auto-commit)
  always_comb begin
    shd_sync_d = shd_sync_q;
    shd_p_d    = shd_p_q;
    shd_n_d    = shd_n_q;
    shd_cur_d  = shd_cur_q;
    act_sync_d = act_sync_q;
    act_p_d    = act_p_q;
    act_n_d    = act_n_q;
    act_cur_d  = act_cur_q;
    if (apply) begin
      act_sync_d = shd_sync_q;
      act_p_d    = shd_p_q;
      act_n_d    = shd_n_q;
      act_cur_d  = shd_cur_q;
    end
    // Channel writes are stalled while ARMED, so they never meet an apply.
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_wr && (idx[7:2] == 6'(c))) begin
        case (idx[1:0])
          2'd0: begin
            shd_sync_d[c*DEL_W +: DEL_W] = i_wb_data[DEL_W-1:0];
            if (auto_q) act_sync_d[c*DEL_W +: DEL_W] = i_wb_data[DEL_W-1:0];
          end
          2'd1: begin
            shd_p_d[c*DEL_W +: DEL_W] = i_wb_data[DEL_W-1:0];
            if (auto_q) act_p_d[c*DEL_W +: DEL_W] = i_wb_data[DEL_W-1:0];
          end
          2'd2: begin
            shd_n_d[c*DEL_W +: DEL_W] = i_wb_data[DEL_W-1:0];
            if (auto_q) act_n_d[c*DEL_W +: DEL_W] = i_wb_data[DEL_W-1:0];
          end
          default: begin
            shd_cur_d[c*CUR_W +: CUR_W] = i_wb_data[CUR_W-1:0];
            if (auto_q) act_cur_d[c*CUR_W +: CUR_W] = i_wb_data[CUR_W-1:0];
          end
        endcase
      end
    end
  end

  // Ack and read data; read data is nonzero only in the ack cycle
  always_comb begin
    ack_d   = acc;
    rdata_d = 32'd0;
`ifdef DRV_CFG_READBACK_EN
    if (rd) begin
      if (is_ch) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (idx[7:2] == 6'(c)) begin
            case (idx[1:0])
              2'd0:    rdata_d = 32'(shd_sync_q[c*DEL_W +: DEL_W]);
              2'd1:    rdata_d = 32'(shd_p_q[c*DEL_W +: DEL_W]);
              2'd2:    rdata_d = 32'(shd_n_q[c*DEL_W +: DEL_W]);
              default: rdata_d = 32'(shd_cur_q[c*CUR_W +: CUR_W]);
            endcase
          end
        end
      end else begin
        case (idx)
          8'hF0:   rdata_d = {30'd0, auto_q, 1'b0};
          8'hF1:   rdata_d = {30'd0, timeout_q, armed};
          8'hF2:   rdata_d = {8'(NUM_CH), 8'(DEL_W), 8'(CUR_W), 8'h02};
          default: rdata_d = 32'd0;
        endcase
      end
    end
`else
    if (rd) rdata_d = 32'd0;
`endif
  end

  // All state flops; reset clears everything and abandons a pending commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      auto_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
      shd_sync_q <= '0;
      shd_p_q    <= '0;
      shd_n_q    <= '0;
      shd_cur_q  <= '0;
      act_sync_q <= '0;
      act_p_q    <= '0;
      act_n_q    <= '0;
      act_cur_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      auto_q     <= auto_d;
      timeout_q  <= timeout_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      shd_sync_q <= shd_sync_d;
      shd_p_q    <= shd_p_d;
      shd_n_q    <= shd_n_d;
      shd_cur_q  <= shd_cur_d;
      act_sync_q <= act_sync_d;
      act_p_q    <= act_p_d;
      act_n_q    <= act_n_d;
      act_cur_q  <= act_cur_d;
    end
  end

  assign o_wb_ack       = ack_q;
  assign o_wb_data      = rdata_q;
  assign o_commit_busy  = (state_q == ARMED);
  assign o_del_sync     = act_sync_q;
  assign o_del_p        = act_p_q;
  assign o_del_n        = act_n_q;
  assign o_current      = act_cur_q;
  assign o_del_sync_inv = ~act_sync_q;
  assign o_del_p_inv    = ~act_p_q;
  assign o_del_n_inv    = ~act_n_q;

endmodule

// File: tb/tb_wb_drv_config_mc.sv
// Directed bench for wb_drv_config_mc (NUM_CH=2, DEL_W=16, CUR_W=32,
// COMMIT_TIMEOUT=8). Inputs change on the falling edge; outputs are sampled
// on the falling edge, away from the active rising edge.
module tb_wb_drv_config_mc;

  localparam int NUM_CH = 2;
  localparam int DEL_W  = 16;
  localparam int CUR_W  = 32;

`ifdef DRV_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0]             wb_addr = 32'd0, wb_wdata = 32'd0;
  logic                    wb_ack, wb_stall;
  logic [31:0]             wb_rdata;
  logic                    frame_sync = 1'b0;
  logic [NUM_CH*DEL_W-1:0] del_sync, del_p, del_n;
  logic [NUM_CH*DEL_W-1:0] del_sync_inv, del_p_inv, del_n_inv;
  logic [NUM_CH*CUR_W-1:0] current;
  logic                    busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  wb_drv_config_mc #(
    .NUM_CH(NUM_CH), .DEL_W(DEL_W), .CUR_W(CUR_W),
    .BASE_ADDR(32'h0300_0000), .COMMIT_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata),
    .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdata),
    .i_frame_sync(frame_sync),
    .o_del_sync(del_sync), .o_del_p(del_p), .o_del_n(del_n),
    .o_del_sync_inv(del_sync_inv), .o_del_p_inv(del_p_inv),
    .o_del_n_inv(del_n_inv),
    .o_current(current), .o_commit_busy(busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus request: waits out stall (bounded), returns ack/data of ack cycle
  task automatic wb_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output logic acked, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wdata;
    #1;
    n = 0;
    while (wb_stall && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      chk_cnt++; err_cnt++;
      $display("FAIL stall_bound: got stalled expected accept");
    end
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    acked = wb_ack;
    rdata = wb_rdata;
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic a;
    logic [31:0] d;
    wb_access(1'b1, addr, wdata, a, d);
    check_eq("wr_ack", {63'd0, a}, 64'd1);
  endtask

  task automatic wb_read_check(input string tag, input logic [31:0] addr,
                               input logic [31:0] exp);
    logic a;
    logic [31:0] d;
    wb_access(1'b0, addr, 32'd0, a, d);
    check_eq({tag, "_ack"}, {63'd0, a}, 64'd1);
    check_eq(tag, {32'd0, d}, {32'd0, exp});
  endtask

  initial begin
    logic a;
    logic [31:0] d;

    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_sync_inv", {32'd0, del_sync_inv}, 64'hFFFF_FFFF);
    check_eq("rst_current", current, 64'd0);
    check_eq("rst_ack", {63'd0, wb_ack}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_rdata", {32'd0, wb_rdata}, 64'd0);

    // ID, unmapped in-page index, out-of-page address
    wb_read_check("id", 32'h0300_00F2, RB ? 32'h0210_2002 : 32'd0);
    wb_read_check("unmapped", 32'h0300_00F5, 32'd0);
    wb_access(1'b0, 32'h0400_0000, 32'd0, a, d);
    check_eq("offpage_ack0", {63'd0, a}, 64'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_eq("offpage_ack", {63'd0, wb_ack}, 64'd0);
    end

    // Shadow write, arm, stalled channel write, then frame sync apply
    wb_write(32'h0300_0001, 32'hFFFF_FFFF);
    check_eq("shadow_only_p", {32'd0, del_p}, 64'd0);
    wb_write(32'h0300_00F0, 32'h1);
    check_eq("armed_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_addr = 32'h0300_0007; wb_wdata = 32'h0000_ABCD;
    #1;
    check_eq("stall_armed", {63'd0, wb_stall}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_eq("stall_hold", {63'd0, wb_stall}, 64'd1);
      check_eq("p_pre_sync", {48'd0, del_p[15:0]}, 64'd0);
    end
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    #1;
    check_eq("p_applied", {48'd0, del_p[15:0]}, 64'hFFFF);
    check_eq("p_inv_applied", {48'd0, del_p_inv[15:0]}, 64'd0);
    check_eq("busy_after_sync", {63'd0, busy}, 64'd0);
    check_eq("stall_released", {63'd0, wb_stall}, 64'd0);
    @(negedge clk);
    check_eq("late_wr_ack", {63'd0, wb_ack}, 64'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check_eq("cur1_shadow_only", {32'd0, current[63:32]}, 64'd0);
    wb_read_check("rb_cur1", 32'h0300_0007, RB ? 32'h0000_ABCD : 32'd0);
    wb_read_check("rb_p0", 32'h0300_0001, RB ? 32'h0000_FFFF : 32'd0);

    // Timeout commit after 8 ARMED cycles, sticky flag and clear
    wb_write(32'h0300_00F0, 32'h1);
    check_eq("to_busy0", {63'd0, busy}, 64'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check_eq("to_busy", {63'd0, busy}, 64'd1);
      check_eq("to_cur_hold", {32'd0, current[63:32]}, 64'd0);
    end
    @(negedge clk);
    check_eq("to_busy_end", {63'd0, busy}, 64'd0);
    check_eq("to_cur_applied", {32'd0, current[63:32]}, 64'h0000_ABCD);
    wb_read_check("status_to", 32'h0300_00F1, RB ? 32'h2 : 32'd0);
    wb_write(32'h0300_00F1, 32'h2);
    wb_read_check("status_clr", 32'h0300_00F1, 32'd0);

    // AUTO mode: channel write reaches active outputs by the ack cycle
    wb_write(32'h0300_00F0, 32'h2);
    wb_read_check("ctrl_auto", 32'h0300_00F0, RB ? 32'h2 : 32'd0);
    wb_access(1'b1, 32'h0300_0006, 32'h0000_1234, a, d);
    check_eq("auto_ack", {63'd0, a}, 64'd1);
    check_eq("auto_n1", {48'd0, del_n[31:16]}, 64'h1234);
    check_eq("auto_n1_inv", {48'd0, del_n_inv[31:16]}, 64'hEDCB);
    check_eq("auto_n0", {48'd0, del_n[15:0]}, 64'd0);
    check_eq("auto_no_busy", {63'd0, busy}, 64'd0);

    // COMMIT accepted together with frame sync waits for the next sync
    wb_write(32'h0300_00F0, 32'h0);
    wb_write(32'h0300_0000, 32'h0000_55AA);
    check_eq("sync0_not_auto", {48'd0, del_sync[15:0]}, 64'd0);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_addr = 32'h0300_00F0; wb_wdata = 32'h1; frame_sync = 1'b1;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; frame_sync = 1'b0;
    check_eq("same_cyc_ack", {63'd0, wb_ack}, 64'd1);
    check_eq("same_cyc_busy", {63'd0, busy}, 64'd1);
    check_eq("same_cyc_no_apply", {48'd0, del_sync[15:0]}, 64'd0);
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    check_eq("next_sync_apply", {48'd0, del_sync[15:0]}, 64'h55AA);
    check_eq("next_sync_idle", {63'd0, busy}, 64'd0);

    // Reset while ARMED: no apply, active registers cleared
    wb_write(32'h0300_00F0, 32'h1);
    check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_arm_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_arm_cur", current, 64'd0);
    check_eq("rst_arm_p_inv", {32'd0, del_p_inv}, 64'hFFFF_FFFF);
    check_eq("rst_arm_sync", {32'd0, del_sync}, 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
